ahb_mem_slave: RTL and testbench

- AHB-Lite responder: the slave end of the AHB bus that the bridge test environment drives as master.
- Accepts pipelined address and data phases and services them from an internal word memory.
- Inserts a programmable number of wait states and returns a two-cycle ERROR response for illegal transfers.
- Serves as the AHB-side reference target for driver/monitor bring-up, and as a stand-in slave next to the AHB-to-APB bridge.

---
 rtl/ahb_pkg.sv | 38 +++
 rtl/ahb_byte_lane_dec.sv | 29 ++
 rtl/ahb_mem_slave.sv | 132 +++++++++++++
 tb/tb_ahb_mem_slave.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespError = 2'b01
  } hresp_t;

  localparam logic [2:0] HsizeByte = 3'd0;
  localparam logic [2:0] HsizeHalf = 3'd1;
  localparam logic [2:0] HsizeWord = 3'd2;

  typedef enum logic [2:0] {
    BurstSingle = 3'd0,
    BurstIncr   = 3'd1,
    BurstWrap4  = 3'd2,
    BurstIncr4  = 3'd3,
    BurstWrap8  = 3'd4,
    BurstIncr8  = 3'd5,
    BurstWrap16 = 3'd6,
    BurstIncr16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StErr1 = 2'd2,
    StErr2 = 2'd3
  } slv_state_e;

endpackage

// File: rtl/ahb_byte_lane_dec.sv
// Decodes transfer size and low address bits into little-endian byte-lane strobes.
module ahb_byte_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] strb,
  output logic       misalign
);

  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    case (size)
      HsizeByte: strb = 4'b0001 << addr;
      HsizeHalf: begin
        strb     = addr[1] ? 4'b1100 : 4'b0011;
        misalign = addr[0];
      end
      HsizeWord: begin
        strb     = 4'b1111;
        misalign = |addr;
      end
      // Sizes above a word are not supported by this memory.
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder with programmable wait states and two-cycle ERROR responses.
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        Hresetn,
  input  logic [31:0] Haddr,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hburst,
  input  logic [31:0] Hwdata,
  input  logic        Hreadyin,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WaitLoad = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  slv_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          dp_active_q, dp_active_d;
  logic          dp_write_q, dp_write_d;
  logic [AW-1:0] dp_word_q, dp_word_d;
  logic [3:0]    dp_strb_q, dp_strb_d;

  logic [31:0]   mem [DEPTH];

  htrans_t       trans;
  logic          trans_active;
  logic          out_of_range;
  logic          misalign;
  logic [3:0]    lane_strb;
  logic          sample_ok;
  logic          complete;
  logic          unused_hburst;

  assign unused_hburst = ^Hburst;

  ahb_byte_lane_dec u_lane_dec (
    .size     (Hsize),
    .addr     (Haddr[1:0]),
    .strb     (lane_strb),
    .misalign (misalign)
  );

  assign trans        = htrans_t'(Htrans);
  assign trans_active = (trans == TransNonseq) || (trans == TransSeq);
  assign out_of_range = {2'b00, Haddr[31:2]} >= 32'(DEPTH);
  // Addresses are only accepted while this slave is presenting ready.
  assign sample_ok    = Hreadyin && ((state_q == StIdle) || (state_q == StErr2));
  assign complete     = (state_q == StIdle) && dp_active_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dp_active_d = dp_active_q;
    dp_write_d  = dp_write_q;
    dp_word_d   = dp_word_q;
    dp_strb_d   = dp_strb_q;
    case (state_q)
      StIdle, StErr2: begin
        if (sample_ok) begin
          state_d     = StIdle;
          dp_active_d = 1'b0;
          if (trans_active) begin
            if (out_of_range || misalign) begin
              state_d = StErr1;
            end else begin
              dp_active_d = 1'b1;
              dp_write_d  = Hwrite;
              dp_word_d   = Haddr[AW+1:2];
              dp_strb_d   = lane_strb;
              if (WAIT_STATES > 0) begin
                state_d = StWait;
                cnt_d   = WaitLoad;
              end
            end
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      dp_active_q <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_word_q   <= '0;
      dp_strb_q   <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dp_active_q <= dp_active_d;
      dp_write_q  <= dp_write_d;
      dp_word_q   <= dp_word_d;
      dp_strb_q   <= dp_strb_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (complete && dp_write_q && Hreadyin) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_strb_q[i]) begin
          mem[dp_word_q][8*i +: 8] <= Hwdata[8*i +: 8];
        end
      end
    end
  end

  assign Hreadyout = !((state_q == StWait) || (state_q == StErr1));
  assign Hresp     = ((state_q == StErr1) || (state_q == StErr2)) ? RespError : RespOkay;
  assign Hrdata    = (complete && !dp_write_q) ? mem[dp_word_q] : 32'h0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed cycle-table bench for ahb_mem_slave with one and zero wait-state instances.
module tb_ahb_mem_slave;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;

  typedef struct {
    logic        sel0;
    logic        stall;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  logic        clock;
  logic        Hresetn;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic [31:0] Hwdata;
  logic        hreadyin;
  logic        sel0;
  logic        stall;
  logic        ready1, ready0;
  logic [1:0]  resp1, resp0;
  logic [31:0] rdata1, rdata0;

  int n_checks;
  int n_fail;

  assign hreadyin = stall ? 1'b0 : (sel0 ? ready0 : ready1);

  ahb_mem_slave #(.DEPTH(256), .WAIT_STATES(1)) dut (
    .clock     (clock),
    .Hresetn   (Hresetn),
    .Haddr     (Haddr),
    .Htrans    (Htrans),
    .Hwrite    (Hwrite),
    .Hsize     (Hsize),
    .Hburst    (Hburst),
    .Hwdata    (Hwdata),
    .Hreadyin  (hreadyin),
    .Hreadyout (ready1),
    .Hresp     (resp1),
    .Hrdata    (rdata1)
  );

  ahb_mem_slave #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clock     (clock),
    .Hresetn   (Hresetn),
    .Haddr     (Haddr),
    .Htrans    (Htrans),
    .Hwrite    (Hwrite),
    .Hsize     (Hsize),
    .Hburst    (Hburst),
    .Hwdata    (Hwdata),
    .Hreadyin  (hreadyin),
    .Hreadyout (ready0),
    .Hresp     (resp0),
    .Hrdata    (rdata0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic s0, input logic st, input logic [1:0] tr,
                              input logic wr, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic er, input logic [1:0] eresp,
                              input logic [31:0] erd);
    vec_t v;
    v = '{s0, st, tr, wr, sz, a, wd, er, eresp, erd};
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd);
    @(posedge clock);
    #1;
    Htrans = tr;
    Hwrite = wr;
    Hsize  = 3'd2;
    Haddr  = a;
    Hwdata = wd;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Hresetn  = 1'b0;
    Haddr    = 32'h0;
    Htrans   = TI;
    Hwrite   = 1'b0;
    Hsize    = 3'd2;
    Hburst   = 3'd0;
    Hwdata   = 32'h0;
    sel0     = 1'b0;
    stall    = 1'b0;

    // Word write then read of 0x10, one wait state each.
    add(0, 0, TN, 1, 2, 32'h10, 32'h0, 1, 0, 32'h0);
    add(0, 0, TN, 0, 2, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
    add(0, 0, TN, 0, 2, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 0, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'hDEADBEEF);
    // Byte and half lane writes into 0x20.
    add(0, 0, TN, 1, 2, 32'h20, 32'h0, 1, 0, 32'h0);
    add(0, 0, TN, 1, 0, 32'h21, 32'h0, 0, 0, 32'h0);
    add(0, 0, TN, 1, 0, 32'h21, 32'h0, 1, 0, 32'h0);
    add(0, 0, TN, 1, 1, 32'h22, 32'h0000AB00, 0, 0, 32'h0);
    add(0, 0, TN, 1, 1, 32'h22, 32'h0000AB00, 1, 0, 32'h0);
    add(0, 0, TN, 0, 2, 32'h20, 32'h12340000, 0, 0, 32'h0);
    add(0, 0, TN, 0, 2, 32'h20, 32'h12340000, 1, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 0, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'h1234AB00);
    // Last legal word.
    add(0, 0, TN, 1, 2, 32'h3FC, 32'h0, 1, 0, 32'h0);
    add(0, 0, TN, 0, 2, 32'h3FC, 32'h0BADF00D, 0, 0, 32'h0);
    add(0, 0, TN, 0, 2, 32'h3FC, 32'h0BADF00D, 1, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 0, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'h0BADF00D);
    // Errors: out-of-range read, then misaligned word write; 0x04 must keep its value.
    add(0, 0, TN, 1, 2, 32'h04, 32'h0, 1, 0, 32'h0);
    add(0, 0, TN, 0, 2, 32'h400, 32'h5555AAAA, 0, 0, 32'h0);
    add(0, 0, TN, 0, 2, 32'h400, 32'h5555AAAA, 1, 0, 32'h0);
    add(0, 0, TN, 1, 2, 32'h06, 32'hFFFFFFFF, 0, 1, 32'h0);
    add(0, 0, TN, 1, 2, 32'h06, 32'hFFFFFFFF, 1, 1, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'hFFFFFFFF, 0, 1, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'hFFFFFFFF, 1, 1, 32'h0);
    add(0, 0, TN, 0, 2, 32'h04, 32'h0, 1, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 0, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'h5555AAAA);
    // Bus stall: NONSEQ held while ready is low elsewhere.
    add(0, 1, TN, 0, 2, 32'h10, 32'h0, 1, 0, 32'h0);
    add(0, 1, TN, 0, 2, 32'h10, 32'h0, 1, 0, 32'h0);
    add(0, 1, TN, 0, 2, 32'h10, 32'h0, 1, 0, 32'h0);
    add(0, 0, TN, 0, 2, 32'h10, 32'h0, 1, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 0, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'hDEADBEEF);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'h0);
    add(0, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'h0);
    // Zero-wait INCR4 write with a BUSY beat, then INCR4 read.
    add(1, 0, TN, 1, 2, 32'h40, 32'h0, 1, 0, 32'h0);
    add(1, 0, TS, 1, 2, 32'h44, 32'd1, 1, 0, 32'h0);
    add(1, 0, TB, 1, 2, 32'h48, 32'd2, 1, 0, 32'h0);
    add(1, 0, TS, 1, 2, 32'h48, 32'hBADBAD00, 1, 0, 32'h0);
    add(1, 0, TS, 1, 2, 32'h4C, 32'd3, 1, 0, 32'h0);
    add(1, 0, TI, 0, 2, 32'h0, 32'd4, 1, 0, 32'h0);
    add(1, 0, TN, 0, 2, 32'h40, 32'h0, 1, 0, 32'h0);
    add(1, 0, TS, 0, 2, 32'h44, 32'h0, 1, 0, 32'd1);
    add(1, 0, TS, 0, 2, 32'h48, 32'h0, 1, 0, 32'd2);
    add(1, 0, TS, 0, 2, 32'h4C, 32'h0, 1, 0, 32'd3);
    add(1, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'd4);
    add(1, 0, TI, 0, 2, 32'h0, 32'h0, 1, 0, 32'h0);

    #12;
    chk("reset ready1", 32'(ready1), 32'h1);
    chk("reset resp1", 32'(resp1), 32'h0);
    chk("reset rdata1", rdata1, 32'h0);
    chk("reset ready0", 32'(ready0), 32'h1);
    chk("reset resp0", 32'(resp0), 32'h0);
    chk("reset rdata0", rdata0, 32'h0);
    Hresetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #1;
      sel0   = vecs[i].sel0;
      stall  = vecs[i].stall;
      Htrans = vecs[i].trans;
      Hwrite = vecs[i].write;
      Hsize  = vecs[i].size;
      Haddr  = vecs[i].addr;
      Hwdata = vecs[i].wdata;
      Hburst = vecs[i].sel0 ? 3'd3 : 3'd0;
      @(negedge clock);
      if (vecs[i].sel0) begin
        chk($sformatf("vec%0d ready", i), 32'(ready0), 32'(vecs[i].exp_ready));
        chk($sformatf("vec%0d resp", i), 32'(resp0), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d rdata", i), rdata0, vecs[i].exp_rdata);
      end else begin
        chk($sformatf("vec%0d ready", i), 32'(ready1), 32'(vecs[i].exp_ready));
        chk($sformatf("vec%0d resp", i), 32'(resp1), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d rdata", i), rdata1, vecs[i].exp_rdata);
      end
    end

    // Asynchronous reset during a WAIT cycle must drop the pending write.
    sel0   = 1'b0;
    stall  = 1'b0;
    Hburst = 3'd0;
    drive(TI, 1'b0, 32'h0, 32'h0);
    drive(TI, 1'b0, 32'h0, 32'h0);
    drive(TN, 1'b1, 32'h30, 32'h0);
    drive(TI, 1'b0, 32'h0, 32'hCAFEF00D);
    drive(TI, 1'b0, 32'h0, 32'hCAFEF00D);
    @(negedge clock);
    chk("rst_seq fill ready", 32'(ready1), 32'h1);
    drive(TN, 1'b1, 32'h30, 32'h0);
    drive(TI, 1'b0, 32'h0, 32'h11111111);
    @(negedge clock);
    chk("rst_seq wait ready", 32'(ready1), 32'h0);
    #1;
    Hresetn = 1'b0;
    #1;
    chk("rst_async ready", 32'(ready1), 32'h1);
    chk("rst_async resp", 32'(resp1), 32'h0);
    chk("rst_async rdata", rdata1, 32'h0);
    @(posedge clock);
    #1;
    Hresetn = 1'b1;
    drive(TN, 1'b0, 32'h30, 32'h11111111);
    drive(TI, 1'b0, 32'h0, 32'h11111111);
    @(negedge clock);
    chk("rst_read wait ready", 32'(ready1), 32'h0);
    drive(TI, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    chk("rst_read ready", 32'(ready1), 32'h1);
    chk("rst_read rdata", rdata1, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
